reaction_score_keeper: RTL
==========================

# reaction_score_keeper

- Downstream consumer of the reaction-timer stage.
- Captures each frozen 4-digit BCD reaction time when the timer stops.
- Keeps the last result, the best (lowest) result, a short history ring, a trial counter and a false-start counter.
- Muxes one selected quantity onto a 16-bit BCD bus that drives the 4-digit hex display.

## Interface
Parameters:
- HIST_DEPTH, 4: history ring entries; power of two, 2..8.
- HIST_AW, 2: log2(HIST_DEPTH); width of hist_idx.

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- result_valid  in  1  one-cycle pulse; result_bcd holds a completed reaction time.
- result_bcd  in  16  packed BCD {d3,d2,d1,d0}, milliseconds.
- false_start  in  1  one-cycle pulse; reaction key pressed before the LED turned on.
- clear_best  in  1  one-cycle pulse; invalidates the best score.
- view_sel  in  2  display source: 00 last, 01 best, 10 history, 11 counters.
- hist_idx  in  HIST_AW  history entry to view; 0 = most recent.
- disp_bcd  out  16  BCD value for the hex display.
- best_valid  out  1  a best score exists.
- new_best  out  1  the last accepted result set a new best; held until the next accepted result, clear_best or reset.
- bad_digit  out  1  sticky; a result containing a digit >9 was rejected.

## Operation
- Capture stage (S0): each cycle, register result_valid, false_start, clear_best and result_bcd.
- Update stage (S1): acts on the registered values with fixed priority: reset > false_start > clear_best > result_valid.
- false_start:
  - Increments false_cnt (2-digit BCD, saturates at 99).
  - Discards any simultaneous result.
  - Leaves last, best and history unchanged.
- clear_best:
  - best_valid←0, new_best←0.
  - If a valid result arrives in the same cycle, the clear is applied first, so that result becomes best.
- result_valid with any digit >9:
  - bad_digit←1.
  - Result dropped: no counters, last, best or history change.
- Valid result:
  - last←result.
  - History write at wr_ptr; wr_ptr increments and wraps modulo HIST_DEPTH.
  - trial_cnt increments (2-digit BCD, saturates at 99).
- Best update for a valid result:
  - If !best_valid, or result < best (unsigned compare of packed BCD equals numeric order): best←result, best_valid←1, new_best←1.
  - Otherwise new_best←0.
  - Equal to best is not a new best.
- History read:
  - Entry = ring[(wr_ptr−1−hist_idx) mod HIST_DEPTH].
  - Entries never written read 16'h0000 (hist_fill counter, saturates at HIST_DEPTH).
- Display mux (registered):
  - 00: last.
  - 01: best, or 16'h0000 when !best_valid.
  - 10: history entry.
  - 11: {trial_cnt, false_cnt}.

## Timing
- Reset values: disp_bcd 16'h0000, best_valid 0, new_best 0, bad_digit 0. Counters, pointers and the ring are all zero.
- Latency: a pulse at cycle N is in state at N+2. disp_bcd reflects it at N+3.
- view_sel/hist_idx change at cycle N → disp_bcd updates at N+1.
- Back-to-back result_valid pulses are each accepted, in order; no backpressure.
- Reset asserted mid-pipeline: in-flight pulses are discarded; outputs show reset values on the cycle after reset is sampled.
- Ring wrap: the (HIST_DEPTH+1)th result overwrites the oldest; hist_idx=0 always shows the newest.

## Structure
- Shared package:
  - BCD digit width constant (4).
  - View-select encodings: VIEW_LAST, VIEW_BEST, VIEW_HIST, VIEW_CNT.
  - BCD-99 saturation constant.
- One natural sub-module: bcd2_sat_counter, a 2-digit BCD incrementer with synchronous reset, enable and saturation at 99. It is instantiated twice (trial_cnt, false_cnt).

## Test plan
- Reset, then results 0x0350, 0x0210, 0x0400:
  - view 01 → 0x0210; new_best=0 after the third result.
  - view 11 → 0x0300.
- Six results 0x0101..0x0106, hist_idx 0..3:
  - Shows 0x0106, 0x0105, 0x0104, 0x0103 (wrap verified).
  - With only 2 results, hist_idx 3 shows 0x0000.
- result_valid 0x0123 and false_start in the same cycle:
  - false_cnt=1, trial_cnt=0, last unchanged, best_valid=0.
- result_bcd 0x01A5:
  - bad_digit=1, trial_cnt unchanged.
  - bad_digit holds until reset.
- best 0x0200, then clear_best simultaneous with result 0x0500:
  - best=0x0500, best_valid=1, new_best=1.
- 100 valid results:
  - trial_cnt saturates at 0x99.
  - Reset during a result pulse → disp_bcd 0x0000, all counters 0.

Source files
------------

// File: rtl/reaction_score_keeper_pkg.sv
// Shared constants, display-source encodings and BCD helpers for the reaction score keeper.
package reaction_score_keeper_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam logic [7:0] BCD_SAT_99 = 8'h99;

    typedef enum logic [1:0] {
        VIEW_LAST = 2'b00,
        VIEW_BEST = 2'b01,
        VIEW_HIST = 2'b10,
        VIEW_CNT  = 2'b11
    } viewSel_t;

    // True when every nibble of a 4-digit packed BCD value is a legal decimal digit.
    function automatic logic bcdDigitsOk(input logic [4*BCD_DIGIT_W-1:0] value);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (value[i*BCD_DIGIT_W +: BCD_DIGIT_W] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/reaction_score_keeper_bcd2_sat_counter.sv
// Two-digit BCD up-counter that sticks at 99 instead of rolling over.
module bcd2_sat_counter
    import reaction_score_keeper_pkg::*;
(
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       enable,
    output logic [7:0] count
);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            count <= 8'h00;
        end else if (enable && (count != BCD_SAT_99)) begin
            if (count[3:0] == 4'd9) begin
                count <= {count[7:4] + 4'd1, 4'd0};
            end else begin
                count <= {count[7:4], count[3:0] + 4'd1};
            end
        end
    end

endmodule

// File: rtl/reaction_score_keeper.sv
// Collects frozen BCD reaction times: last, best, history ring and trial/false-start counts,
// and muxes one of them onto the 4-digit hex display.
module reaction_score_keeper
    import reaction_score_keeper_pkg::*;
#(
    parameter int HIST_DEPTH = 4,
    parameter int HIST_AW    = 2
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               result_valid,
    input  logic [15:0]        result_bcd,
    input  logic               false_start,
    input  logic               clear_best,
    input  logic [1:0]         view_sel,
    input  logic [HIST_AW-1:0] hist_idx,
    output logic [15:0]        disp_bcd,
    output logic               best_valid,
    output logic               new_best,
    output logic               bad_digit
);

    localparam logic [HIST_AW:0]   FILL_MAX = (HIST_AW+1)'(HIST_DEPTH);
    localparam logic [HIST_AW-1:0] PTR_ONE  = HIST_AW'(1);

    logic               validQ;
    logic               falseQ;
    logic               clearQ;
    logic [15:0]        bcdQ;

    logic [15:0]        lastBcd;
    logic [15:0]        bestBcd;
    logic [15:0]        ring [HIST_DEPTH];
    logic [HIST_AW-1:0] wrPtr;
    logic [HIST_AW:0]   histFill;
    logic [7:0]         trialCnt;
    logic [7:0]         falseCnt;

    logic               digitsOk;
    logic               acceptResult;
    logic               takeBest;
    logic [HIST_AW-1:0] rdIdx;
    logic [15:0]        histRead;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            validQ <= 1'b0;
            falseQ <= 1'b0;
            clearQ <= 1'b0;
            bcdQ   <= 16'h0000;
        end else begin
            validQ <= result_valid;
            falseQ <= false_start;
            clearQ <= clear_best;
            bcdQ   <= result_bcd;
        end
    end

    // A same-cycle clear is applied first, so the arriving result competes against an empty best.
    assign digitsOk     = bcdDigitsOk(bcdQ);
    assign acceptResult = validQ && !falseQ && digitsOk;
    assign takeBest     = clearQ || !best_valid || (bcdQ < bestBcd);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            lastBcd    <= 16'h0000;
            bestBcd    <= 16'h0000;
            best_valid <= 1'b0;
            new_best   <= 1'b0;
            bad_digit  <= 1'b0;
            wrPtr      <= '0;
            histFill   <= '0;
            for (int i = 0; i < HIST_DEPTH; i++) begin
                ring[i] <= 16'h0000;
            end
        end else if (!falseQ) begin
            if (clearQ) begin
                best_valid <= 1'b0;
                new_best   <= 1'b0;
            end
            if (validQ && !digitsOk) begin
                bad_digit <= 1'b1;
            end
            if (acceptResult) begin
                lastBcd     <= bcdQ;
                ring[wrPtr] <= bcdQ;
                wrPtr       <= wrPtr + PTR_ONE;
                if (histFill != FILL_MAX) begin
                    histFill <= histFill + 1'b1;
                end
                if (takeBest) begin
                    bestBcd    <= bcdQ;
                    best_valid <= 1'b1;
                    new_best   <= 1'b1;
                end else begin
                    new_best   <= 1'b0;
                end
            end
        end
    end

    bcd2_sat_counter trialCounter (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .enable   (acceptResult),
        .count    (trialCnt)
    );

    bcd2_sat_counter falseCounter (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .enable   (falseQ),
        .count    (falseCnt)
    );

    // Index 0 is the newest entry; slots not yet written read as zero.
    assign rdIdx    = wrPtr - PTR_ONE - hist_idx;
    assign histRead = ({1'b0, hist_idx} < histFill) ? ring[rdIdx] : 16'h0000;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            disp_bcd <= 16'h0000;
        end else begin
            case (view_sel)
                VIEW_LAST: disp_bcd <= lastBcd;
                VIEW_BEST: disp_bcd <= best_valid ? bestBcd : 16'h0000;
                VIEW_HIST: disp_bcd <= histRead;
                VIEW_CNT:  disp_bcd <= {trialCnt, falseCnt};
                default:   disp_bcd <= 16'h0000;
            endcase
        end
    end

endmodule
